// File: rtl/fios_res_collector_if.sv
// Result-stream bundle between the FIOS multiplier, the result collector and its consumer.
// The slave modport is the collector's view; the master modport drives it.
interface fios_res_collector_if #(
  parameter int WORD_W = 17
);
  logic [WORD_W-1:0] RES_i;
  logic              RES_push_i;
  logic              done_i;
  logic [WORD_W-1:0] res_data_o;
  logic              res_valid_o;
  logic              res_last_o;
  logic              res_ready_i;
  logic              can_start_o;
  logic              busy_o;

  modport slave (
    input  RES_i, RES_push_i, done_i, res_ready_i,
    output res_data_o, res_valid_o, res_last_o, can_start_o, busy_o
  );

  modport master (
    output RES_i, RES_push_i, done_i, res_ready_i,
    input  res_data_o, res_valid_o, res_last_o, can_start_o, busy_o
  );
endinterface

// File: rtl/fios_res_collector.sv
// Ping-pong collector for FIOS Montgomery results, streamed out over valid/ready.
// Optional sticky error flags are built when FIOS_RES_COLLECT_ERR_EN is defined.
module fios_res_collector #(
  parameter int s      = 8,
  parameter int WORD_W = 17
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  fios_res_collector_if.slave  bus
`ifdef FIOS_RES_COLLECT_ERR_EN
  ,
  output logic                 err_overflow_o,
  output logic                 err_count_o
`endif
);

  localparam int CW = $clog2(s + 1);
  localparam int RW = $clog2(s);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  logic [WORD_W-1:0] r_bank [2][s];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [CW-1:0]     r_wr_cnt;
  logic [RW-1:0]     r_rd_cnt;
  state_t            r_state;
  logic              r_valid;
  logic              r_last;
  logic [WORD_W-1:0] r_data;
  logic              r_can_start;
  logic              r_busy;

  logic              w_wr_full;
  logic              w_push_ok;
  logic              w_done_ok;
  logic              w_xfer;
  logic              w_rd_last;
  logic              w_drain;
  logic              w_rd_other;
  logic [RW-1:0]     w_rd_cnt_inc;
  logic [CW-1:0]     w_wr_cnt_inc;
  logic [CW-1:0]     w_wr_cnt_nxt;
  logic              w_wr_bank_nxt;
  logic [1:0]        w_full_nxt;

  assign w_wr_full     = r_full[r_wr_bank];
  assign w_push_ok     = bus.RES_push_i & ~w_wr_full & (r_wr_cnt < CW'(s));
  assign w_done_ok     = bus.done_i & ~w_wr_full;
  assign w_xfer        = r_valid & bus.res_ready_i;
  assign w_rd_last     = (r_rd_cnt == RW'(s - 1));
  assign w_drain       = w_xfer & w_rd_last;
  assign w_rd_other    = ~r_rd_bank;
  assign w_rd_cnt_inc  = r_rd_cnt + 1'b1;
  assign w_wr_cnt_inc  = r_wr_cnt + CW'(w_push_ok);
  assign w_wr_cnt_nxt  = w_done_ok ? '0 : w_wr_cnt_inc;
  assign w_wr_bank_nxt = r_wr_bank ^ w_done_ok;

  // A close and a drain never hit the same bank: only a full bank drains, only a free one closes.
  always_comb begin
    w_full_nxt = r_full;
    if (w_done_ok) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_drain)   w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (w_push_ok) r_bank[r_wr_bank][r_wr_cnt[RW-1:0]] <= bus.RES_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_can_start <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_can_start <= ~w_full_nxt[w_wr_bank_nxt] & (w_wr_cnt_nxt == '0);
      r_busy      <= (|w_full_nxt) | (w_wr_cnt_nxt != '0);
    end
  end

  // Read FSM: the next word is preloaded on each transfer so outputs stay registered.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state  <= ST_STREAM;
            r_rd_cnt <= '0;
            r_valid  <= 1'b1;
            r_last   <= 1'b0;
            r_data   <= r_bank[r_rd_bank][0];
          end
        end
        ST_STREAM: begin
          if (w_xfer) begin
            if (w_rd_last) begin
              r_rd_bank <= w_rd_other;
              r_rd_cnt  <= '0;
              r_last    <= 1'b0;
              if (r_full[w_rd_other]) begin
                r_data <= r_bank[w_rd_other][0];
              end else begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
              end
            end else begin
              r_rd_cnt <= w_rd_cnt_inc;
              r_data   <= r_bank[r_rd_bank][w_rd_cnt_inc];
              r_last   <= (w_rd_cnt_inc == RW'(s - 1));
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIOS_RES_COLLECT_ERR_EN
  logic r_err_ovf;
  logic r_err_cnt;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err_ovf <= 1'b0;
      r_err_cnt <= 1'b0;
    end else begin
      if ((bus.RES_push_i & ~w_push_ok) | (bus.done_i & ~w_done_ok)) r_err_ovf <= 1'b1;
      if (w_done_ok & (w_wr_cnt_inc < CW'(s))) r_err_cnt <= 1'b1;
    end
  end

  assign err_overflow_o = r_err_ovf;
  assign err_count_o    = r_err_cnt;
`endif

  assign bus.res_data_o  = r_data;
  assign bus.res_valid_o = r_valid;
  assign bus.res_last_o  = r_last;
  assign bus.can_start_o = r_can_start;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_fios_res_collector.sv
// Scoreboard bench for fios_res_collector (s=4): closed products queue their words,
// a negedge monitor pops and compares each accepted word and checks output hold under backpressure.
module tb_fios_res_collector;

  localparam int S = 4;
  localparam int W = 17;

  logic clk;
  logic rst_n;

  fios_res_collector_if #(.WORD_W(W)) bus ();

`ifdef FIOS_RES_COLLECT_ERR_EN
  logic err_ovf;
  logic err_cnt;
`endif

  fios_res_collector #(.s(S), .WORD_W(W)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
`ifdef FIOS_RES_COLLECT_ERR_EN
    ,
    .err_overflow_o (err_ovf),
    .err_count_o    (err_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  logic [W:0]   q[$];
  logic [W-1:0] mdl_bank [2][S];
  int           mdl_wb  = 0;
  int           mdl_cnt = 0;

  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_eq("hold_valid", 32'(bus.res_valid_o), 32'd1);
        check_eq("hold_data",  32'(bus.res_data_o), 32'(prev_data));
        check_eq("hold_last",  32'(bus.res_last_o), 32'(prev_last));
      end
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (q.size() == 0) begin
          check_eq("unexpected_word", 32'(bus.res_data_o), 32'hFFFF_FFFF);
        end else begin
          logic [W:0] e;
          e = q.pop_front();
          check_eq("word_data", 32'(bus.res_data_o), 32'(e[W-1:0]));
          check_eq("word_last", 32'(bus.res_last_o), 32'(e[W]));
        end
        n_pop++;
      end
      hold_prev = bus.res_valid_o & ~bus.res_ready_i;
      prev_data = bus.res_data_o;
      prev_last = bus.res_last_o;
    end
  end

  task automatic step(input logic p, input logic [W-1:0] d, input logic dn);
    bus.RES_push_i = p;
    bus.RES_i      = d;
    bus.done_i     = dn;
    @(posedge clk);
    #1;
    bus.RES_push_i = 1'b0;
    bus.done_i     = 1'b0;
  endtask

  task automatic mdl_close();
    for (int i = 0; i < S; i++) q.push_back({(i == S - 1), mdl_bank[mdl_wb][i]});
    mdl_wb  = 1 - mdl_wb;
    mdl_cnt = 0;
  endtask

  task automatic push_acc(input logic [W-1:0] d);
    mdl_bank[mdl_wb][mdl_cnt] = d;
    mdl_cnt++;
    step(1'b1, d, 1'b0);
  endtask

  task automatic done_acc();
    step(1'b0, '0, 1'b1);
    mdl_close();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !bus.res_valid_o) break;
    end
    check_eq(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"},     32'(bus.res_valid_o), 32'd0);
    check_eq({tag, "_last"},      32'(bus.res_last_o),  32'd0);
    check_eq({tag, "_data"},      32'(bus.res_data_o),  32'd0);
    check_eq({tag, "_can_start"}, 32'(bus.can_start_o), 32'd1);
    check_eq({tag, "_busy"},      32'(bus.busy_o),      32'd0);
`ifdef FIOS_RES_COLLECT_ERR_EN
    check_eq({tag, "_err_ovf"},   32'(err_ovf), 32'd0);
    check_eq({tag, "_err_cnt"},   32'(err_cnt), 32'd0);
`endif
  endtask

  initial begin
    int base;
    rst_n           = 1'b0;
    bus.RES_i       = '0;
    bus.RES_push_i  = 1'b0;
    bus.done_i      = 1'b0;
    bus.res_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic stream, done one cycle after the last push.
    bus.res_ready_i = 1'b1;
    push_acc(17'h00011);
    check_eq("can_start_after_push", 32'(bus.can_start_o), 32'd0);
    check_eq("busy_after_push",      32'(bus.busy_o),      32'd1);
    push_acc(17'h00022);
    push_acc(17'h00033);
    push_acc(17'h00044);
    step(1'b0, '0, 1'b0);
    done_acc();
    check_eq("valid_at_close",  32'(bus.res_valid_o), 32'd0);
    @(posedge clk);
    #1;
    check_eq("valid_after_close", 32'(bus.res_valid_o), 32'd1);
    wait_drain("drain_basic");

    // Done coincident with the last push.
    push_acc(17'h00101);
    push_acc(17'h00102);
    push_acc(17'h00103);
    mdl_bank[mdl_wb][mdl_cnt] = 17'h1FFFF;
    step(1'b1, 17'h1FFFF, 1'b1);
    mdl_close();
    check_eq("can_start_coincident", 32'(bus.can_start_o), 32'd1);
    wait_drain("drain_coincident");

    // Backpressure, ping-pong, overflow.
    bus.res_ready_i = 1'b0;
    for (int i = 0; i < S; i++) push_acc(17'h0A001 + 17'(i));
    done_acc();
    check_eq("can_start_one_full", 32'(bus.can_start_o), 32'd1);
    for (int i = 0; i < S; i++) push_acc(17'h0B001 + 17'(i));
    done_acc();
    check_eq("can_start_both_full", 32'(bus.can_start_o), 32'd0);
    step(1'b1, 17'h0AAAA, 1'b0);
    check_eq("busy_both_full",    32'(bus.busy_o),      32'd1);
    check_eq("held_first_valid",  32'(bus.res_valid_o), 32'd1);
    check_eq("held_first_data",   32'(bus.res_data_o),  32'h0A001);
`ifdef FIOS_RES_COLLECT_ERR_EN
    check_eq("err_overflow_set",  32'(err_ovf), 32'd1);
    check_eq("err_count_clear",   32'(err_cnt), 32'd0);
`endif
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 2 * S; i++) begin
      @(negedge clk);
      check_eq("b2b_valid", 32'(bus.res_valid_o), 32'd1);
    end
    wait_drain("drain_pingpong");
    check_eq("can_start_after_drain", 32'(bus.can_start_o), 32'd1);

    // Short product: the unwritten slot streams stale data.
    push_acc(17'h0C001);
    push_acc(17'h0C002);
    push_acc(17'h0C003);
    done_acc();
`ifdef FIOS_RES_COLLECT_ERR_EN
    check_eq("err_count_set", 32'(err_cnt), 32'd1);
`endif
    wait_drain("drain_short");

    // Reset while word 2 is on the output.
    for (int i = 0; i < S; i++) push_acc(17'h0D001 + 17'(i));
    done_acc();
    base = n_pop;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (n_pop >= base + 2) break;
    end
    check_eq("pops_before_reset", 32'(n_pop - base), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    q.delete();
    mdl_wb  = 0;
    mdl_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    base = n_pop;
    for (int i = 0; i < S; i++) push_acc(17'h0E001 + 17'(i));
    done_acc();
    wait_drain("drain_after_reset");
    check_eq("pops_after_reset", 32'(n_pop - base), 32'(S));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fios_res_collector.md
Name: fios_res_collector

Overview:
- Downstream neighbour of the FIOS multiplier. Captures the s result words of one Montgomery product, each 17 bits wide, as they are pushed out.
- Holds them in a ping-pong (two-bank) buffer and streams them to the consumer over a valid/ready handshake.
- The FIOS pipeline cannot stall. This block therefore tells the launch logic via can_start_o when a free bank exists for the next multiplication.

Parameters:
- s, 8, number of 17-bit words per result; must be at least 2.
- WORD_W, 17, word width; fixed to the DSP limb width, not overridable in practice.

Ports:
- clock_i  in  1  system clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- RES_i  in  WORD_W  result word from the multiplier.
- RES_push_i  in  1  RES_i valid this cycle; one word per pulse, LSW first.
- done_i  in  1  end-of-product pulse; coincides with or follows the last push.
- res_data_o  out  WORD_W  streamed result word.
- res_valid_o  out  1  res_data_o valid.
- res_last_o  out  1  marks word s-1 of a result.
- res_ready_i  in  1  consumer accepts word.
- can_start_o  out  1  write bank is free; launch logic may assert start to the multiplier.
- busy_o  out  1  any bank full or write in progress.

Behaviour:
- Reset (async assert, sync deassert upstream):
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, both full flags=0.
  - res_valid_o=0, res_last_o=0, res_data_o=0, can_start_o=1, busy_o=0.
  - Reset mid-operation discards all stored words and any partial write.
- Write side:
  - On RES_push_i with wr_cnt<s and full[wr_bank]=0: bank[wr_bank][wr_cnt]<=RES_i, then wr_cnt++.
  - On done_i: set full[wr_bank]=1, toggle wr_bank, clear wr_cnt.
  - If RES_push_i and done_i coincide: the word is written first, then the bank closes in the same edge.
  - A push with wr_cnt==s, or into a full bank, is dropped. Storage and counters are unchanged.
  - A done_i into an already-full bank is ignored.
- can_start_o = ~full[wr_bank] & (wr_cnt==0), registered. It drops the cycle after the first push of a product. It reasserts the cycle after the close, provided the other bank is free.
- Read side FSM, two states:
  - IDLE: res_valid_o=0. Go to STREAM when full[rd_bank]=1, with rd_cnt=0.
  - STREAM: res_valid_o=1, res_data_o=bank[rd_bank][rd_cnt], res_last_o=(rd_cnt==s-1).
    - On res_valid_o & res_ready_i: rd_cnt++.
    - On the last transfer: clear full[rd_bank], toggle rd_bank, rd_cnt=0. Stay in STREAM if the other bank is already full (back-to-back, no bubble); otherwise go to IDLE.
- First word latency: res_valid_o rises 1 cycle after the done_i edge that closes the bank.
- Handshake rules:
  - res_data_o, res_last_o and res_valid_o are stable while res_valid_o & ~res_ready_i.
  - Outputs are registered, not combinational from res_ready_i.
- A bank close and a bank drain in the same cycle always target different banks; both take effect.
- busy_o = full[0] | full[1] | (wr_cnt!=0).

Optional Feature:
- Macro: FIOS_RES_COLLECT_ERR_EN.
- When defined, adds two sticky outputs, cleared only by reset:
  - err_overflow_o: set on any dropped push or ignored done_i.
  - err_count_o: set when done_i closes a bank holding fewer than s words, counting a coincident push.
- A short bank is still closed and streamed; unwritten slots output stale data.
- When undefined: the ports are absent, no error logic is synthesised, and drops are silent.

Test Plan:
- Basic stream (s=4): push 0x00011, 0x00022, 0x00033, 0x00044, then done_i one cycle after the last push, res_ready_i=1 → the four words are output in order; res_last_o only on 0x00044; res_valid_o rises 1 cycle after done_i.
- Coincident done (s=4): done_i on the same cycle as the 4th push (0x1FFFF) → 0x1FFFF is captured as word 3; can_start_o returns to 1 the next cycle.
- Backpressure plus ping-pong (s=4):
  - Result A is pushed and res_ready_i held low, then result B is pushed → can_start_o=0 after B closes.
  - Release ready → A0..A3 then B0..B3 stream with no idle cycle between A3 and B0.
- Overflow: with both banks full, push 0x0AAAA → storage unchanged, stream unaffected; err_overflow_o=1 with FIOS_RES_COLLECT_ERR_EN.
- Short product (s=4): 3 pushes then done_i → err_count_o=1 (macro on); 4 words are still streamed.
- Reset mid-stream: assert reset_n_i low during word 2 of a stream → all outputs are at reset values within the same cycle; after release, a new 4-word product streams correctly.
